// File: rtl/bcd_scan_driver_pkg.sv
`default_nettype none
// ============================================================================
// Package  : bcd_pkg
// Purpose  : Shared constants, FSM state type and width helpers for the
//            BCD scan driver.
// Revision : 1.0 - initial release
// ============================================================================
package bcd_pkg;

    localparam int BCD_W       = 4;
    localparam int ADD3_THRESH = 5;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        CONV = 1'b1
    } conv_state_t;

    // Minimum of 1 so that single-entry counters still get a legal width.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        if (r == 0) begin
            r = 1;
        end
        return r;
    endfunction

    function automatic longint unsigned pow10(input int n);
        longint unsigned p;
        p = 64'd1;
        for (int i = 0; i < n; i++) begin
            p = p * 64'd10;
        end
        return p;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_scan_driver_bin2bcd_seq.sv
`default_nettype none
// ============================================================================
// Module   : bin2bcd_seq
// Purpose  : Sequential double-dabble converter with valid/ready intake and
//            a single-cycle done strobe carrying the finished BCD word.
// Revision : 1.0 - initial release
// ============================================================================
module bin2bcd_seq
    import bcd_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int NUM_DIGITS = 3
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          i_valid,
    input  logic [DATA_W-1:0]             i_data,
    output logic                          o_ready,
    output logic                          o_busy,
    output logic                          o_done,
    output logic [NUM_DIGITS*BCD_W-1:0]   o_bcd
);

    localparam int c_BCD_TOT = NUM_DIGITS * BCD_W;
    localparam int c_SR_W    = c_BCD_TOT + DATA_W;
    localparam int c_ITER_W  = clog2(DATA_W);

    conv_state_t         r_state;
    logic [c_SR_W-1:0]   r_sr;
    logic [c_ITER_W-1:0] r_iter;
    logic                r_ready;
    logic                r_busy;

    logic [c_SR_W-1:0]   w_adj;
    logic [c_SR_W-1:0]   w_shift;
    logic                w_last;

    always_comb begin
        w_adj = r_sr;
        for (int d = 0; d < NUM_DIGITS; d++) begin
            if (r_sr[DATA_W + d*BCD_W +: BCD_W] >= BCD_W'(ADD3_THRESH)) begin
                w_adj[DATA_W + d*BCD_W +: BCD_W] = r_sr[DATA_W + d*BCD_W +: BCD_W] + BCD_W'(3);
            end
        end
        w_shift = w_adj << 1;
    end

    // The final shift result is handed out combinationally so the display
    // register captures it on the very edge the conversion completes.
    assign w_last  = (r_state == CONV) && (r_iter == c_ITER_W'(DATA_W - 1));
    assign o_done  = w_last;
    assign o_bcd   = w_shift[c_SR_W-1 -: c_BCD_TOT];
    assign o_ready = r_ready;
    assign o_busy  = r_busy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_sr    <= '0;
            r_iter  <= '0;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_valid && r_ready) begin
                        r_sr    <= {{c_BCD_TOT{1'b0}}, i_data};
                        r_iter  <= '0;
                        r_state <= CONV;
                        r_ready <= 1'b0;
                        r_busy  <= 1'b1;
                    end
                end
                CONV: begin
                    r_sr   <= w_shift;
                    r_iter <= r_iter + c_ITER_W'(1);
                    if (w_last) begin
                        r_state <= IDLE;
                        r_ready <= 1'b1;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_ready <= 1'b1;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/bcd_scan_driver.sv
`default_nettype none
// ============================================================================
// Module   : bcd_scan_driver
// Purpose  : Binary-to-BCD conversion feeding a time-multiplexed digit bus
//            with one-hot active-low digit select and leading-zero blanking.
// Revision : 1.0 - initial release
// ============================================================================
module bcd_scan_driver
    import bcd_pkg::*;
#(
    parameter int DATA_W         = 8,
    parameter int NUM_DIGITS     = 3,
    parameter int REFRESH_CYCLES = 50000,
    parameter int BLANK_LZ       = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   load_valid,
    input  logic [DATA_W-1:0]      load_data,
    output logic                   load_ready,
    output logic                   busy,
    output logic [BCD_W-1:0]       bcd_digit,
    output logic                   seg_en,
    output logic [NUM_DIGITS-1:0]  an_n
);

    localparam int c_BCD_TOT = NUM_DIGITS * BCD_W;
    localparam int c_CNT_W   = clog2(REFRESH_CYCLES);
    localparam int c_IDX_W   = clog2(NUM_DIGITS);

    localparam longint unsigned c_BIN_RANGE = longint'(1) << DATA_W;
    localparam longint unsigned c_DEC_RANGE = pow10(NUM_DIGITS);

    generate
        if ((c_BIN_RANGE > c_DEC_RANGE) || (NUM_DIGITS < 1) || (NUM_DIGITS > 8) ||
            (REFRESH_CYCLES < 2)) begin : g_param_check
            $fatal(1, "bcd_scan_driver: illegal DATA_W/NUM_DIGITS/REFRESH_CYCLES combination");
        end
    endgenerate

    logic                  w_done;
    logic [c_BCD_TOT-1:0]  w_bcd;

    logic [c_BCD_TOT-1:0]  r_disp;
    logic [c_CNT_W-1:0]    r_refresh;
    logic [c_IDX_W-1:0]    r_idx;

    logic [NUM_DIGITS-1:0] w_nz;
    logic [NUM_DIGITS-1:0] w_an;
    logic [BCD_W-1:0]      w_digit;
    logic                  w_show;

    bin2bcd_seq #(
        .DATA_W     (DATA_W),
        .NUM_DIGITS (NUM_DIGITS)
    ) u_conv (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_valid (load_valid),
        .i_data  (load_data),
        .o_ready (load_ready),
        .o_busy  (busy),
        .o_done  (w_done),
        .o_bcd   (w_bcd)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_disp <= '0;
        end else if (w_done) begin
            r_disp <= w_bcd;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_refresh <= '0;
            r_idx     <= '0;
        end else if (r_refresh == c_CNT_W'(REFRESH_CYCLES - 1)) begin
            r_refresh <= '0;
            if (r_idx == c_IDX_W'(NUM_DIGITS - 1)) begin
                r_idx <= '0;
            end else begin
                r_idx <= r_idx + c_IDX_W'(1);
            end
        end else begin
            r_refresh <= r_refresh + c_CNT_W'(1);
        end
    end

    // w_nz[i] is set when nibble i or any more significant nibble is non-zero.
    always_comb begin
        w_nz    = '0;
        w_an    = '1;
        w_digit = '0;
        w_show  = 1'b1;
        w_nz[NUM_DIGITS-1] = |r_disp[(NUM_DIGITS-1)*BCD_W +: BCD_W];
        for (int i = NUM_DIGITS - 2; i >= 0; i--) begin
            w_nz[i] = w_nz[i+1] | (|r_disp[i*BCD_W +: BCD_W]);
        end
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (r_idx == c_IDX_W'(i)) begin
                w_digit = r_disp[i*BCD_W +: BCD_W];
                w_an[i] = 1'b0;
                w_show  = (i == 0) || w_nz[i] || (BLANK_LZ == 0);
            end
        end
    end

    assign bcd_digit = w_digit;
    assign seg_en    = w_show;
    assign an_n      = w_an;

endmodule
`default_nettype wire

// File: tb/tb_bcd_scan_driver.sv
`default_nettype none
// ============================================================================
// Module   : tb_bcd_scan_driver
// Purpose  : Self-checking bench for bcd_scan_driver, blanking and non-blanking
//            instances side by side against a value-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bcd_scan_driver;

    localparam int c_DW  = 8;
    localparam int c_ND  = 3;
    localparam int c_RC  = 4;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            load_valid = 1'b0;
    logic [c_DW-1:0] load_data = '0;

    logic            ready_b, busy_b, seg_b;
    logic [3:0]      digit_b;
    logic [c_ND-1:0] an_b;
    logic            ready_s, busy_s, seg_s;
    logic [3:0]      digit_s;
    logic [c_ND-1:0] an_s;

    int n_checks = 0;
    int n_err    = 0;

    // Reference model: value shown, edges since reset, pending conversion.
    int m_cycle = 0;
    int m_value = 0;
    int m_pend  = 0;
    int m_left  = 0;

    always #5 clk = ~clk;

    bcd_scan_driver #(
        .DATA_W(c_DW), .NUM_DIGITS(c_ND), .REFRESH_CYCLES(c_RC), .BLANK_LZ(1)
    ) u_dut_blank (
        .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_data(load_data),
        .load_ready(ready_b), .busy(busy_b), .bcd_digit(digit_b), .seg_en(seg_b), .an_n(an_b)
    );

    bcd_scan_driver #(
        .DATA_W(c_DW), .NUM_DIGITS(c_ND), .REFRESH_CYCLES(c_RC), .BLANK_LZ(0)
    ) u_dut_show (
        .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_data(load_data),
        .load_ready(ready_s), .busy(busy_s), .bcd_digit(digit_s), .seg_en(seg_s), .an_n(an_s)
    );

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cycle <= 0;
            m_value <= 0;
            m_pend  <= 0;
            m_left  <= 0;
        end else begin
            m_cycle <= m_cycle + 1;
            if (m_left > 0) begin
                m_left <= m_left - 1;
                if (m_left == 1) m_value <= m_pend;
            end else if (load_valid) begin
                m_pend <= int'(load_data);
                m_left <= c_DW;
            end
        end
    end

    always @(negedge clk) begin : p_compare
        int idx, p, dig, vis;
        idx = (m_cycle / c_RC) % c_ND;
        p   = (idx == 0) ? 1 : ((idx == 1) ? 10 : 100);
        dig = (m_value / p) % 10;
        vis = (idx == 0 || m_value >= p) ? 1 : 0;
        check("model_an_n_b",   int'(an_b),    int'(3'b111 & ~(3'b001 << idx)));
        check("model_an_n_s",   int'(an_s),    int'(3'b111 & ~(3'b001 << idx)));
        check("model_digit_b",  int'(digit_b), dig);
        check("model_digit_s",  int'(digit_s), dig);
        check("model_seg_en_b", int'(seg_b),   vis);
        check("model_seg_en_s", int'(seg_s),   1);
        check("model_busy",     int'(busy_b),  (m_left > 0) ? 1 : 0);
        check("model_ready",    int'(ready_b), (m_left > 0) ? 0 : 1);
        check("model_ready_s",  int'(ready_s), (m_left > 0) ? 0 : 1);
    end

    // Watches one full scan rotation and pins each digit/enable to literals.
    task automatic scan_expect(input string tag, input bit show_dut,
                               input int d2, input int d1, input int d0,
                               input int s2, input int s1, input int s0);
        logic [2:0] an;
        int dg, sg;
        repeat (c_RC * c_ND) begin
            @(negedge clk);
            an = show_dut ? an_s : an_b;
            dg = show_dut ? int'(digit_s) : int'(digit_b);
            sg = show_dut ? int'(seg_s) : int'(seg_b);
            case (an)
                3'b110: begin check({tag, "_d0"}, dg, d0); check({tag, "_en0"}, sg, s0); end
                3'b101: begin check({tag, "_d1"}, dg, d1); check({tag, "_en1"}, sg, s1); end
                3'b011: begin check({tag, "_d2"}, dg, d2); check({tag, "_en2"}, sg, s2); end
                default: check({tag, "_an_onehot"}, int'(an), 6);
            endcase
        end
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (!ready_b && n < 50) begin
            @(posedge clk); #1; n++;
        end
        check({tag, "_ready_timeout"}, int'(ready_b), 1);
    endtask

    // Accepts one value and measures the busy window in clock edges.
    task automatic load(input int v);
        int n;
        wait_idle("load");
        load_valid = 1'b1;
        load_data  = c_DW'(v);
        @(posedge clk); #1;
        load_valid = 1'b0;
        n = 0;
        while (busy_b && n < 20) begin
            @(posedge clk); #1; n++;
        end
        check("accept_to_done_latency", n, c_DW);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        check("reset_an_n",   int'(an_b),    6);
        check("reset_digit",  int'(digit_b), 0);
        check("reset_seg_en", int'(seg_b),   1);
        check("reset_ready",  int'(ready_b), 1);
        check("reset_busy",   int'(busy_b),  0);
        scan_expect("reset_scan", 1'b0, 0, 0, 0, 0, 0, 1);

        load(255);
        scan_expect("ff", 1'b0, 2, 5, 5, 1, 1, 1);

        load(7);
        scan_expect("h07_blank", 1'b0, 0, 0, 7, 0, 0, 1);
        scan_expect("h07_show",  1'b1, 0, 0, 7, 1, 1, 1);

        wait_idle("d100");
        load_valid = 1'b1;
        load_data  = 8'd100;
        @(posedge clk); #1;
        load_data  = 8'd42;
        repeat (3) begin @(posedge clk); #1; end
        load_valid = 1'b0;
        wait_idle("d100_done");
        scan_expect("d100_ignore42", 1'b0, 1, 0, 0, 1, 1, 1);
        load(42);
        scan_expect("d42", 1'b0, 0, 4, 2, 0, 1, 1);

        wait_idle("d200");
        load_valid = 1'b1;
        load_data  = 8'd200;
        @(posedge clk); #1;
        load_valid = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_an_n",   int'(an_b),    6);
        check("async_rst_digit",  int'(digit_b), 0);
        check("async_rst_seg_en", int'(seg_b),   1);
        check("async_rst_ready",  int'(ready_b), 1);
        check("async_rst_busy",   int'(busy_b),  0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (20) @(posedge clk);
        scan_expect("after_abort", 1'b0, 0, 0, 0, 0, 0, 1);

        repeat (400) begin
            @(posedge clk); #1;
            load_valid = ($urandom_range(0, 2) == 0);
            load_data  = c_DW'($urandom_range(0, 255));
        end
        load_valid = 1'b0;
        wait_idle("random_end");

        for (int v = 0; v < 256; v++) begin
            load(v);
            scan_expect("sweep", 1'b1, (v / 100) % 10, (v / 10) % 10, v % 10, 1, 1, 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
`default_nettype wire
